// File: rtl/macc_seq.sv
// macc_seq -- dot-product sequencer for an external multiply-accumulate block.
//
// Streams unsigned 8-bit operand pairs into a MACC (dataa/datab/clken/sload),
// waits for the MACC pipeline to flush, then presents the 16-bit accumulated
// sum on a valid/ready result port.
//
// Ports
//   Clk, aclr_n            clock, asynchronous active-low reset
//   start, len             begin a dot product of len element pairs (IDLE only)
//   in_valid/in_ready      operand beat handshake, operands in_a / in_b
//   m_dataa, m_datab       registered operands to the MACC
//   m_clken, m_sload       MACC clock enable / load-instead-of-accumulate
//   m_aclr                 MACC clear, the combinational inverse of aclr_n
//   m_result               MACC adder_out
//   res_valid/res_ready    result handshake, sum on res_data
//   busy                   high whenever the sequencer is not IDLE
module macc_seq #(
  parameter int MACC_LAT = 2,
  parameter int LEN_W    = 8
) (
  input  logic             Clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             in_ready,
  output logic [7:0]       m_dataa,
  output logic [7:0]       m_datab,
  output logic             m_clken,
  output logic             m_sload,
  output logic             m_aclr,
  input  logic [15:0]      m_result,
  output logic             res_valid,
  output logic [15:0]      res_data,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  // Drain counter must reach MACC_LAT+1.
  localparam int DRN_W = $clog2(MACC_LAT + 2);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MACC_LAT + 1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [DRN_W-1:0] dcnt_q, dcnt_d;
  logic [7:0]       dataa_q, dataa_d;
  logic [7:0]       datab_q, datab_d;
  logic             clken_q, clken_d;
  logic             sload_q, sload_d;
  logic             res_valid_q, res_valid_d;
  logic [15:0]      res_data_q, res_data_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             accept;

  // in_ready_q is high exactly in ACC, so this is the beat handshake.
  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    dcnt_d      = dcnt_q;
    dataa_d     = dataa_q;
    datab_d     = datab_q;
    // Enable/sload are single-cycle strobes; any cycle without a beat freezes the MACC.
    clken_d     = 1'b0;
    sload_d     = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = ACC;
            cnt_d   = len;
            first_d = 1'b1;
          end else begin
            // Empty vector: answer zero without touching the MACC.
            state_d     = DONE;
            res_data_d  = 16'd0;
            res_valid_d = 1'b1;
          end
        end
      end
      ACC: begin
        if (accept) begin
          dataa_d = in_a;
          datab_d = in_b;
          clken_d = 1'b1;
          // Loading the first product clears the previous vector's sum.
          sload_d = first_q;
          first_d = 1'b0;
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DRAIN;
            dcnt_d  = '0;
          end
        end
      end
      DRAIN: begin
        // One edge for the operand register plus MACC_LAT edges of MACC pipeline.
        if (dcnt_q == DRN_LAST) begin
          res_data_d  = m_result;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          dcnt_d = dcnt_q + DRN_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == ACC);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      dcnt_q      <= '0;
      dataa_q     <= 8'd0;
      datab_q     <= 8'd0;
      clken_q     <= 1'b0;
      sload_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'd0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      dcnt_q      <= dcnt_d;
      dataa_q     <= dataa_d;
      datab_q     <= datab_d;
      clken_q     <= clken_d;
      sload_q     <= sload_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign m_dataa   = dataa_q;
  assign m_datab   = datab_q;
  assign m_clken   = clken_q;
  assign m_sload   = sload_q;
  // The MACC clears together with the controller.
  assign m_aclr    = ~aclr_n;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_macc_seq.sv
module tb_macc_seq;
  localparam int MACC_LAT = 2;
  localparam int LEN_W    = 8;

  logic             Clk = 1'b0;
  logic             aclr_n;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [7:0]       in_a, in_b;
  logic             in_ready;
  logic [7:0]       m_dataa, m_datab;
  logic             m_clken, m_sload, m_aclr;
  logic [15:0]      m_result;
  logic             res_valid;
  logic [15:0]      res_data;
  logic             res_ready;
  logic             busy;

  always #5 Clk = ~Clk;

  macc_seq #(.MACC_LAT(MACC_LAT), .LEN_W(LEN_W)) dut (
    .Clk(Clk), .aclr_n(aclr_n), .start(start), .len(len),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .m_dataa(m_dataa), .m_datab(m_datab), .m_clken(m_clken),
    .m_sload(m_sload), .m_aclr(m_aclr), .m_result(m_result),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .busy(busy)
  );

  // MACC model, latency 2: operand products register on the first edge,
  // the accumulator on the second. clken gates what enters the pipe.
  logic        st_en, st_ld;
  logic [15:0] st_p, acc_q;
  always @(posedge Clk or posedge m_aclr) begin
    if (m_aclr) begin
      st_en <= 1'b0; st_ld <= 1'b0; st_p <= 16'd0; acc_q <= 16'd0;
    end else begin
      st_en <= m_clken;
      st_ld <= m_sload;
      st_p  <= 16'(m_dataa) * 16'(m_datab);
      if (st_en) acc_q <= st_ld ? st_p : acc_q + st_p;
    end
  end
  assign m_result = acc_q;

  int cyc = 0;
  int clken_cnt = 0;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (m_clken) clken_cnt <= clken_cnt + 1;
  end

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  int acc_cyc, start_cyc;

  typedef struct packed {
    logic [7:0]       n;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [3:0]       gap;
    logic [15:0]      exp;
  } vec_t;

  vec_t tbl[5];

  function automatic vec_t mk(input int n, input int gap, input int exp,
                              input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    v.n = 8'(n); v.gap = 4'(gap); v.exp = 16'(exp); v.a = a; v.b = b;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_start(input int n, input logic [15:0] exp, input bit push);
    start = 1'b1;
    len   = LEN_W'(n);
    if (push) exp_q.push_back(exp);
    @(posedge Clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", 32'(busy), 1);
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [7:0] b, input bit first);
    int n;
    in_valid = 1'b1; in_a = a; in_b = b;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge Clk); #1; n++;
    end
    check("beat_ready_seen", 32'(in_ready), 1);
    @(posedge Clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    check("m_clken_on_beat", 32'(m_clken), 1);
    check("m_sload_on_beat", 32'(m_sload), 32'(first));
    check("m_dataa", 32'(m_dataa), 32'(a));
    check("m_datab", 32'(m_datab), 32'(b));
  endtask

  task automatic wait_result(input int exp_lat, input int ref_cyc);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge Clk); #1; n++;
    end
    check("res_valid_seen", 32'(res_valid), 1);
    check("res_latency", cyc - ref_cyc, exp_lat);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: unexpected result %0d, nothing queued", res_data);
    end else begin
      check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    @(posedge Clk); #1;
    res_ready = 1'b0;
    check("res_valid_after_accept", 32'(res_valid), 0);
    check("busy_after_accept", 32'(busy), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int c0;
    c0 = clken_cnt;
    do_start(int'(v.n), v.exp, 1'b1);
    if (v.n == 8'd0) begin
      wait_result(0, start_cyc);
      check("len0_no_clken", clken_cnt - c0, 0);
    end else begin
      for (int i = 0; i < int'(v.n); i++) begin
        send_beat(v.a[i], v.b[i], i == 0);
        if (i == 0) begin
          for (int g = 0; g < int'(v.gap); g++) begin
            @(posedge Clk); #1;
            check("gap_clken", 32'(m_clken), 0);
            check("gap_sload", 32'(m_sload), 0);
            check("gap_dataa_hold", 32'(m_dataa), 32'(v.a[0]));
          end
        end
      end
      wait_result(MACC_LAT + 2, acc_cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    aclr_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = 8'd0; in_b = 8'd0; res_ready = 1'b0;

    tbl[0] = mk(3, 0, 44,    {8'd0, 8'd5, 8'd3, 8'd1},       {8'd0, 8'd6, 8'd4, 8'd2});
    tbl[1] = mk(3, 3, 44,    {8'd0, 8'd5, 8'd3, 8'd1},       {8'd0, 8'd6, 8'd4, 8'd2});
    tbl[2] = mk(2, 0, 64514, {8'd0, 8'd0, 8'd255, 8'd255},   {8'd0, 8'd0, 8'd255, 8'd255});
    tbl[3] = mk(0, 0, 0,     32'd0,                          32'd0);
    tbl[4] = mk(4, 0, 30,    {8'd4, 8'd3, 8'd2, 8'd1},       {8'd4, 8'd3, 8'd2, 8'd1});

    repeat (2) @(posedge Clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_m_clken", 32'(m_clken), 0);
    check("rst_m_sload", 32'(m_sload), 0);
    check("rst_m_dataa", 32'(m_dataa), 0);
    check("rst_m_datab", 32'(m_datab), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_m_aclr", 32'(m_aclr), 1);
    aclr_n = 1'b1;
    #1;
    check("m_aclr_released", 32'(m_aclr), 0);
    @(posedge Clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i]);
      accept_result();
    end

    // Result held with res_ready low; a start arriving meanwhile is dropped.
    run_vec(mk(2, 0, 16, {8'd0, 8'd0, 8'd1, 8'd3}, {8'd0, 8'd0, 8'd1, 8'd5}));
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      check("hold_res_valid", 32'(res_valid), 1);
      check("hold_res_data", 32'(res_data), 16);
      check("hold_in_ready", 32'(in_ready), 0);
      start = (i == 1);
      len   = LEN_W'(1);
    end
    start = 1'b0;
    accept_result();
    repeat (2) begin
      @(posedge Clk); #1;
      check("start_not_queued", 32'(busy), 0);
    end
    run_vec(mk(1, 0, 4, {8'd0, 8'd0, 8'd0, 8'd2}, {8'd0, 8'd0, 8'd0, 8'd2}));
    accept_result();

    // Reset in the middle of a len=4 vector.
    do_start(4, 16'd0, 1'b0);
    send_beat(8'd1, 8'd1, 1'b1);
    send_beat(8'd2, 8'd2, 1'b0);
    #2 aclr_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_m_clken", 32'(m_clken), 0);
    check("mid_rst_m_sload", 32'(m_sload), 0);
    check("mid_rst_m_dataa", 32'(m_dataa), 0);
    check("mid_rst_m_datab", 32'(m_datab), 0);
    check("mid_rst_res_valid", 32'(res_valid), 0);
    check("mid_rst_res_data", 32'(res_data), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_m_aclr", 32'(m_aclr), 1);
    @(posedge Clk); #1;
    aclr_n = 1'b1;
    // First start after release is taken on the very next edge.
    run_vec(mk(1, 0, 63, {8'd0, 8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd0, 8'd9}));
    accept_result();
    seen = 1'b0;
    repeat (8) begin
      @(posedge Clk); #1;
      seen |= res_valid;
    end
    check("no_stray_res_valid", 32'(seen), 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/macc_seq.md
MACC_SEQ -- requirements
Module: macc_seq

Parameters
REQ-001 SHALL have parameter MACC_LAT, default 2, meaning the number of Clk edges from the MACC sampling an operand (clken=1) to that product appearing in adder_out.
REQ-002 SHALL have parameter LEN_W, default 8, meaning the width of the vector-length input.

Interface
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port aclr_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a dot product; honoured only in IDLE.
REQ-006 SHALL have port len, input, LEN_W, the number of element pairs, sampled with start.
REQ-007 SHALL have port in_valid, input, 1, the operand-beat valid.
REQ-008 SHALL have ports in_a and in_b, input, 8 each, the unsigned operand pair.
REQ-009 SHALL have port in_ready, output, 1, the operand-beat ready.
REQ-010 SHALL have ports m_dataa and m_datab, output, 8 each, driving MACC dataa/datab.
REQ-011 SHALL have ports m_clken, m_sload and m_aclr, output, 1 each, driving MACC clken, sload and aclr.
REQ-012 SHALL have port m_result, input, 16, the MACC adder_out.
REQ-013 SHALL have port res_valid, output, 1, result valid.
REQ-014 SHALL have port res_data, output, 16, the dot-product result.
REQ-015 SHALL have port res_ready, input, 1, result accept.
REQ-016 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, ACC, DRAIN and DONE.
REQ-018 IDLE: start=1 with len>0 -> ACC, remaining count = len; start=1 with len=0 -> DONE, res_data=0, MACC untouched.
REQ-019 in_ready SHALL be 1 only in ACC; a beat is accepted on an edge where in_valid and in_ready are both 1.
REQ-020 On an accepted beat at edge k: during cycle k+1, m_dataa=in_a, m_datab=in_b (registered) and m_clken=1; m_sload=1 only for the first beat of a vector, else 0.
REQ-021 Cycles following an edge with no accepted beat SHALL drive m_clken=0 and m_sload=0, freezing the MACC; m_dataa/m_datab hold their last values.
REQ-022 Each accepted beat SHALL decrement the remaining count; accepting the last beat -> DRAIN.
REQ-023 DRAIN SHALL count MACC_LAT+1 edges, then capture m_result into res_data and go to DONE; res_valid rises exactly MACC_LAT+2 edges after the edge accepting the last beat.
REQ-024 DONE: res_valid=1 and res_data stable until res_ready=1 is sampled, then -> IDLE; res_valid=1 with res_ready=1 in the same cycle completes in one cycle.
REQ-025 start asserted outside IDLE SHALL be ignored, with no queuing.
REQ-026 Arithmetic SHALL be unsigned, 8x8 products accumulated modulo 2^16 (MACC wrap); there is no saturation and no overflow flag.
REQ-027 Back-to-back vectors SHALL rely on m_sload for clearing; m_aclr is never pulsed in normal operation.

Reset
REQ-028 aclr_n=0 SHALL immediately force IDLE, count=0, in_ready=0, m_clken=0, m_sload=0, m_dataa=0, m_datab=0, res_valid=0, res_data=0 and busy=0.
REQ-029 m_aclr SHALL equal the inverse of aclr_n combinationally, so the MACC clears with the controller.
REQ-030 Reset mid-operation SHALL discard the vector in progress; no res_valid is produced for it.
REQ-031 After aclr_n deasserts, the first start SHALL be honoured on the next rising edge.

Verification
REQ-032 len=3, beats (1,2),(3,4),(5,6) with in_valid held high -> res_data=44, res_valid 4 edges after the third accept (MACC_LAT=2), m_sload=1 only with the first beat.
REQ-033 Same vector with in_valid low for 3 cycles between beats 1 and 2 -> m_clken=0 during the gap, res_data=44.
REQ-034 len=2, beats (255,255),(255,255) -> res_data=64514 (130050 mod 65536).
REQ-035 start with len=0 -> res_valid on the next cycle with res_data=0, m_clken never 1.
REQ-036 res_ready held low for 5 cycles in DONE -> res_valid and res_data stable throughout; a start during this window is ignored; the second vector (2,2) started afterwards -> res_data=4, proving sload cleared the prior sum.
REQ-037 aclr_n pulsed low after beat 2 of a len=4 vector -> all outputs at reset values, m_aclr=1 during the pulse, no res_valid; a following len=1 vector (7,9) -> res_data=63.
